// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and iterative datapath modes.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MUL  = 3'd2,
      OP_DIV  = 3'd3,
      OP_MOD  = 3'd4,
      OP_SQR  = 3'd5,
      OP_CUBE = 3'd6,
      OP_ZERO = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      EXEC2 = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } iter_mode_e;

   // Opcodes that run on the shared shift-add / restoring-divide datapath.
   function automatic logic op_uses_iter(input op_e o);
      return (o == OP_MUL) || (o == OP_DIV) || (o == OP_MOD) ||
             (o == OP_SQR) || (o == OP_CUBE);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared iterative datapath: WIDTH-step shift-add multiply or restoring divide.
// Outputs are the post-iteration values and are meaningful while done=1.
module alu_iter_muldiv
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  iter_mode_e       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic             prod_hi_nz,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem
);

   // r_acc is the product high half (mul) or partial remainder (div);
   // r_sh is the multiplier shifting out (mul) or dividend/quotient (div).
   logic             r_busy;
   iter_mode_e       r_mode;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_opnd;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_mul_acc;
   logic [WIDTH-1:0] w_mul_sh;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_div_acc;
   logic [WIDTH-1:0] w_div_sh;
   logic [WIDTH-1:0] w_nxt_acc;
   logic [WIDTH-1:0] w_nxt_sh;

   always_comb begin
      w_sum     = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
      w_mul_acc = w_sum[WIDTH:1];
      w_mul_sh  = {w_sum[0], r_sh[WIDTH-1:1]};

      // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
      w_shift   = {r_acc, r_sh[WIDTH-1]};
      w_ge      = (w_shift >= {1'b0, r_opnd});
      w_diff    = w_shift[WIDTH-1:0] - r_opnd;
      w_div_acc = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_div_sh  = {r_sh[WIDTH-2:0], w_ge};

      if (r_mode == MD_DIV) begin
         w_nxt_acc = w_div_acc;
         w_nxt_sh  = w_div_sh;
      end else begin
         w_nxt_acc = w_mul_acc;
         w_nxt_sh  = w_mul_sh;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_mode <= MD_MUL;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_sh   <= '0;
         r_opnd <= '0;
      end else if (start) begin
         r_busy <= 1'b1;
         r_mode <= mode;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_sh   <= (mode == MD_MUL) ? b : a;
         r_opnd <= (mode == MD_MUL) ? a : b;
      end else if (r_busy) begin
         r_acc <= w_nxt_acc;
         r_sh  <= w_nxt_sh;
         if (done) r_busy <= 1'b0;
         else      r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign busy       = r_busy;
   assign done       = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
   assign prod_lo    = w_mul_sh;
   assign prod_hi_nz = |w_mul_acc;
   assign quo        = w_div_sh;
   assign rem        = w_div_acc;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready in and out; mul/div/mod/sqr/cube share one iterative datapath.
// Optional flags output {zero, carry, overflow} is built when ALU_SEQ_FLAGS_EN is defined.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// EXEC  | first iterative pass (mul, sqr, div, mod, cube pass 1)
// EXEC2 | cube pass 2: low product of pass 1 times var1
// DONE  | out_valid high, result held until out_ready
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] var1,
   input  logic [WIDTH-1:0] var2,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
`ifdef ALU_SEQ_FLAGS_EN
   output logic             dbz,
   output logic [2:0]       flags
`else
   output logic             dbz
`endif
);

   state_e           r_state;
   state_e           w_nxt_state;
   logic             r_alive;
   logic [WIDTH-1:0] r_var1;
   op_e              r_op;
   logic             r_bz;
   logic [WIDTH-1:0] r_result;
   logic             r_dbz;

   op_e              w_op;
   logic             w_accept;
   logic             w_it_start;
   iter_mode_e       w_it_mode;
   logic [WIDTH-1:0] w_it_a;
   logic [WIDTH-1:0] w_it_b;
   logic             w_it_busy;
   logic             w_it_done;
   logic [WIDTH-1:0] w_it_prod_lo;
   logic             w_it_hi_nz;
   logic [WIDTH-1:0] w_it_quo;
   logic [WIDTH-1:0] w_it_rem;

   logic             w_res_load;
   logic [WIDTH-1:0] w_res_nxt;
   logic             w_dbz_nxt;

   assign w_op     = op_e'(op);
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_alive <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_alive <= 1'b1;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         IDLE:    if (w_accept)  w_nxt_state = op_uses_iter(w_op) ? EXEC : DONE;
         EXEC:    if (w_it_done) w_nxt_state = (r_op == OP_CUBE) ? EXEC2 : DONE;
         EXEC2:   if (w_it_done) w_nxt_state = DONE;
         DONE:    if (out_ready) w_nxt_state = IDLE;
         default: w_nxt_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = r_alive && (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // Cube pass 2 is launched on the same edge pass 1 finishes, reusing its low product.
   always_comb begin
      w_it_start = (w_accept && op_uses_iter(w_op)) ||
                   ((r_state == EXEC) && w_it_done && (r_op == OP_CUBE));
      if (r_state == IDLE) begin
         w_it_mode = ((w_op == OP_DIV) || (w_op == OP_MOD)) ? MD_DIV : MD_MUL;
         w_it_a    = var1;
         w_it_b    = ((w_op == OP_SQR) || (w_op == OP_CUBE)) ? var1 : var2;
      end else begin
         w_it_mode = MD_MUL;
         w_it_a    = r_var1;
         w_it_b    = w_it_prod_lo;
      end
   end

   alu_iter_muldiv #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (w_it_start),
      .mode       (w_it_mode),
      .a          (w_it_a),
      .b          (w_it_b),
      .busy       (w_it_busy),
      .done       (w_it_done),
      .prod_lo    (w_it_prod_lo),
      .prod_hi_nz (w_it_hi_nz),
      .quo        (w_it_quo),
      .rem        (w_it_rem)
   );

   always_comb begin
      w_res_load = 1'b0;
      w_res_nxt  = r_result;
      w_dbz_nxt  = r_dbz;
      if (w_accept && !op_uses_iter(w_op)) begin
         w_res_load = 1'b1;
         w_dbz_nxt  = 1'b0;
         case (w_op)
            OP_ADD:  w_res_nxt = var1 + var2;
            OP_SUB:  w_res_nxt = var1 - var2;
            default: w_res_nxt = '0;
         endcase
      end else if ((r_state == EXEC) && w_it_done && (r_op != OP_CUBE)) begin
         w_res_load = 1'b1;
         case (r_op)
            OP_DIV: begin
               w_res_nxt = w_it_quo;
               w_dbz_nxt = r_bz;
            end
            OP_MOD: begin
               w_res_nxt = w_it_rem;
               w_dbz_nxt = r_bz;
            end
            default: begin
               w_res_nxt = w_it_prod_lo;
               w_dbz_nxt = 1'b0;
            end
         endcase
      end else if ((r_state == EXEC2) && w_it_done) begin
         w_res_load = 1'b1;
         w_res_nxt  = w_it_prod_lo;
         w_dbz_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_var1   <= '0;
         r_op     <= OP_ADD;
         r_bz     <= 1'b0;
         r_result <= '0;
         r_dbz    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_var1 <= var1;
            r_op   <= w_op;
            r_bz   <= (var2 == '0);
         end
         if (w_res_load) begin
            r_result <= w_res_nxt;
            r_dbz    <= w_dbz_nxt;
         end
      end
   end

   assign result = r_result;
   assign dbz    = r_dbz;

`ifdef ALU_SEQ_FLAGS_EN
   logic [2:0]     r_flags;
   logic           r_ovf1;
   logic           w_carry_nxt;
   logic           w_ovf_nxt;
   logic [WIDTH:0] w_add_c;

   // Cube overflows if either pass leaves a nonzero high half.
   always_comb begin
      w_add_c     = {1'b0, var1} + {1'b0, var2};
      w_carry_nxt = 1'b0;
      w_ovf_nxt   = 1'b0;
      if (w_accept) begin
         if (w_op == OP_ADD)      w_carry_nxt = w_add_c[WIDTH];
         else if (w_op == OP_SUB) w_carry_nxt = (var1 < var2);
      end else if ((r_state == EXEC) && w_it_done &&
                   ((r_op == OP_MUL) || (r_op == OP_SQR))) begin
         w_ovf_nxt = w_it_hi_nz;
      end else if ((r_state == EXEC2) && w_it_done) begin
         w_ovf_nxt = w_it_hi_nz || r_ovf1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= '0;
         r_ovf1  <= 1'b0;
      end else begin
         if (w_res_load) r_flags <= {(w_res_nxt == '0), w_carry_nxt, w_ovf_nxt};
         if ((r_state == EXEC) && w_it_done) r_ovf1 <= w_it_hi_nz;
      end
   end

   assign flags = r_flags;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed test-plan cases, backpressure, reset abort, random ops.
module tb_alu_seq;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  var1;
   logic [W-1:0]  var2;
   logic [2:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          dbz;
`ifdef ALU_SEQ_FLAGS_EN
   logic [2:0]    flags;
`endif

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .var1      (var1),
      .var2      (var2),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
`ifdef ALU_SEQ_FLAGS_EN
      .dbz       (dbz),
      .flags     (flags)
`else
      .dbz       (dbz)
`endif
   );

   typedef struct {
      logic [W-1:0] res;
      logic         dbz;
      logic [2:0]   flg;
      int           lat;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Reference model straight from the arithmetic rules, with a 96-bit exact product.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      logic [95:0] full;
      logic        carry;
      logic        ovf;
      full  = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      e.dbz = 1'b0;
      e.acc = 0;
      case (o)
         3'd0: begin full = 96'(a) + 96'(b); e.res = full[W-1:0]; carry = full[W]; e.lat = 1; end
         3'd1: begin e.res = a - b; carry = (a < b); e.lat = 1; end
         3'd2: begin full = 96'(a) * 96'(b); e.res = full[W-1:0]; ovf = |full[95:W]; e.lat = W + 1; end
         3'd3: begin e.res = (b == 0) ? {W{1'b1}} : a / b; e.dbz = (b == 0); e.lat = W + 1; end
         3'd4: begin e.res = (b == 0) ? a : a % b; e.dbz = (b == 0); e.lat = W + 1; end
         3'd5: begin full = 96'(a) * 96'(a); e.res = full[W-1:0]; ovf = |full[95:W]; e.lat = W + 1; end
         3'd6: begin full = 96'(a) * 96'(a) * 96'(a); e.res = full[W-1:0]; ovf = |full[95:W]; e.lat = 2*W + 1; end
         default: begin e.res = '0; e.lat = 1; end
      endcase
      e.flg = {(e.res == 0), carry, ovf};
      return e;
   endfunction

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: first DONE cycle pops and checks, later DONE cycles check the held result.
   initial begin
      exp_t         e;
      logic         seen;
      logic [W-1:0] held;
      seen = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n || !out_valid) begin
            seen = 1'b0;
         end else if (!seen) begin
            seen = 1'b1;
            held = result;
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("result", result, e.res);
               chk("dbz", 32'(dbz), 32'(e.dbz));
               chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
`ifdef ALU_SEQ_FLAGS_EN
               chk("flags", 32'(flags), 32'(e.flg));
`endif
            end
         end else begin
            chk("result_held", result, held);
         end
      end
   end

   // Called at a negedge; waits for in_ready, presents one request for one cycle.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   t;
      t = 0;
      while ((in_ready !== 1'b1) && (t < 400)) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         chk("in_ready_timeout", 32'(in_ready), 32'd1);
      end else begin
         var1     = a;
         var2     = b;
         op       = o;
         in_valid = 1'b1;
         e        = model(o, a, b);
         e.acc    = cyc + 1;
         exp_q.push_back(e);
         @(negedge clk);
         in_valid = 1'b0;
         var1     = $urandom;
         var2     = $urandom;
         op       = 3'($urandom_range(0, 7));
      end
   endtask

   task automatic wait_drained();
      int t;
      t = 0;
      while (((exp_q.size() != 0) || (out_valid === 1'b1)) && (t < 400)) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [2:0] ro;
      logic [W-1:0] ra, rb;
      int t;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      var1     = '0;
      var2     = '0;
      op       = '0;
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_dbz", 32'(dbz), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      rdy_mode = 2;
      issue(3'd0, 32'hFFFF_FFFF, 32'd1);
      issue(3'd1, 32'd5, 32'd7);
      issue(3'd2, 32'h0001_0000, 32'h0001_0000);
      issue(3'd2, 32'd1234, 32'd5678);
      issue(3'd3, 32'd100, 32'd7);
      issue(3'd4, 32'd100, 32'd7);
      issue(3'd3, 32'd5, 32'd0);
      issue(3'd4, 32'd5, 32'd0);
      issue(3'd6, 32'd3, 32'd0);
      issue(3'd5, 32'h0000_FFFF, 32'd0);
      issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_drained();

      // Backpressure: hold DONE for 10 cycles while a new request is presented.
      rdy_mode = 1;
      @(negedge clk);
      issue(3'd0, 32'd10, 32'd20);
      t = 0;
      while ((out_valid !== 1'b1) && (t < 100)) begin
         @(negedge clk);
         t++;
      end
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      var1     = 32'd77;
      var2     = 32'd1;
      op       = 3'd1;
      repeat (10) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      rdy_mode = 2;
      issue(3'd1, 32'd3, 32'd9);
      wait_drained();

      // Reset during EXEC of a divide aborts it with no stale result.
      issue(3'd3, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (W + 8) @(negedge clk);
      chk("post_rst_no_output", 32'(out_valid), 32'd0);

      // Random traffic with random consumer backpressure.
      rdy_mode = 0;
      for (int i = 0; i < 150; i++) begin
         ro = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       begin ra = 32'($urandom_range(0, 15)); rb = 32'($urandom_range(0, 15)); end
            1:       begin ra = $urandom; rb = '0; end
            2:       begin ra = $urandom; rb = 32'($urandom_range(1, 300)); end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         issue(ro, ra, rb);
      end
      rdy_mode = 2;
      wait_drained();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
